// File: rtl/dcsf_gram_engine_pkg.sv
// Shared types and width helpers for the Gram-threshold engine.
package dcsf_pkg;

   typedef enum logic [2:0] {LOAD, SUM, DIV, THR, WEI, OUT} dcsf_state_e;

   function automatic int dcsf_clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   function automatic int dcsf_gw(input int dw, input int cols);
      return 2 * dw + dcsf_clog2(cols);
   endfunction

   function automatic int dcsf_aw(input int dw, input int ww, input int cols, input int rows);
      return dcsf_gw(dw, cols) + ww + dcsf_clog2(rows);
   endfunction

endpackage

// File: rtl/dcsf_gram_engine_mac_lane.sv
// One output accumulator lane: acc += w*t, plus the output width fitting stage.
// DCSF_SAT_OUT_EN selects saturation instead of truncation when AW > OW.
module dcsf_mac_lane
   import dcsf_pkg::*;
#(
   parameter int GW = 20,
   parameter int WW = 8,
   parameter int AW = 31,
   parameter int OW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [WW-1:0] w,
   input  logic [GW-1:0] t,
   output logic [OW-1:0] y
);

   logic [AW-1:0] acc;

   function automatic logic [OW-1:0] fit_out(input logic [AW-1:0] v);
`ifdef DCSF_SAT_OUT_EN
      if (AW > OW) begin
         if ((v >> OW) != '0) return '1;
      end
`endif
      return OW'(v);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + AW'(w) * AW'(t);
   end

   assign y = fit_out(acc);

endmodule

// File: rtl/dcsf_gram_engine.sv
// Streams A in, builds G = A*A^T, thresholds each row at its mean, then y = T*w.
// Output fitting is controlled by DCSF_SAT_OUT_EN inside dcsf_mac_lane.
module dcsf_gram_engine
   import dcsf_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 16,
   parameter int DW   = 8,
   parameter int WW   = 8,
   parameter int OW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          i_ready,
   input  logic          w_valid,
   input  logic [WW-1:0] w_data,
   output logic          w_ready,
   output logic          o_valid,
   output logic [OW-1:0] o_data,
   output logic          o_last,
   input  logic          o_ready
);

   localparam int GW = dcsf_gw(DW, COLS);
   localparam int AW = dcsf_aw(DW, WW, COLS, ROWS);
   localparam int RB = dcsf_clog2(ROWS);
   localparam int CB = (COLS > 1) ? dcsf_clog2(COLS) : 1;
   localparam int SW = GW + RB;
   localparam logic [RB-1:0] R_LAST = RB'(ROWS - 1);
   localparam logic [CB-1:0] C_LAST = CB'(COLS - 1);

   dcsf_state_e state, state_nxt;

   logic [RB-1:0] r_cnt;
   logic [CB-1:0] c_cnt;
   logic [RB-1:0] step;
   logic [DW-1:0] a_mem [ROWS][COLS];
   logic [GW-1:0] g_mat [ROWS][ROWS];
   logic [SW-1:0] s_vec [ROWS];
   logic [GW-1:0] m_vec [ROWS];
   logic [GW-1:0] prod  [ROWS];
   logic [OW-1:0] y_vec [ROWS];

   logic in_acc, w_acc, o_acc, load_done, lane_clr;

   assign in_acc    = i_valid && i_ready;
   assign w_acc     = w_valid && w_ready;
   assign o_acc     = o_valid && o_ready;
   assign load_done = in_acc && (r_cnt == R_LAST) && (c_cnt == C_LAST);
   assign lane_clr  = ((state == THR) && (step == R_LAST)) || (o_acc && (step == R_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_done) state_nxt = SUM;
         SUM:     if (step == R_LAST) state_nxt = DIV;
         DIV:     state_nxt = THR;
         THR:     if (step == R_LAST) state_nxt = WEI;
         WEI:     if (w_acc && (step == R_LAST)) state_nxt = OUT;
         OUT:     if (o_acc && (step == R_LAST)) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_comb begin
      i_ready = 1'b0;
      w_ready = 1'b0;
      o_valid = 1'b0;
      o_last  = 1'b0;
      o_data  = '0;
      case (state)
         LOAD: i_ready = 1'b1;
         WEI:  w_ready = 1'b1;
         OUT: begin
            o_valid = 1'b1;
            o_last  = (step == R_LAST);
            o_data  = y_vec[step];
         end
         default: ;
      endcase
   end

   // Row k < r comes from storage; the diagonal term uses the incoming element twice.
   always_comb begin
      for (int k = 0; k < ROWS; k++)
         prod[k] = GW'(i_data) * GW'((RB'(k) == r_cnt) ? i_data : a_mem[k][c_cnt]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         c_cnt <= '0;
         step  <= '0;
         for (int i = 0; i < ROWS; i++) begin
            s_vec[i] <= '0;
            m_vec[i] <= '0;
            for (int k = 0; k < ROWS; k++) g_mat[i][k] <= '0;
            for (int c = 0; c < COLS; c++) a_mem[i][c] <= '0;
         end
      end else begin
         case (state)
            LOAD: if (in_acc) begin
               a_mem[r_cnt][c_cnt] <= i_data;
               for (int k = 0; k < ROWS; k++) begin
                  if (RB'(k) < r_cnt) begin
                     g_mat[r_cnt][k] <= g_mat[r_cnt][k] + prod[k];
                     g_mat[k][r_cnt] <= g_mat[k][r_cnt] + prod[k];
                  end else if (RB'(k) == r_cnt) begin
                     g_mat[k][k] <= g_mat[k][k] + prod[k];
                  end
               end
               if (c_cnt == C_LAST) begin
                  c_cnt <= '0;
                  r_cnt <= r_cnt + RB'(1);
               end else begin
                  c_cnt <= c_cnt + CB'(1);
               end
            end
            SUM: begin
               for (int i = 0; i < ROWS; i++) s_vec[i] <= s_vec[i] + SW'(g_mat[step][i]);
               step <= step + RB'(1);
            end
            DIV: begin
               for (int i = 0; i < ROWS; i++) m_vec[i] <= GW'(s_vec[i] >> RB);
            end
            // T overwrites G in place; row r's threshold only ever reads row r.
            THR: begin
               for (int k = 0; k < ROWS; k++)
                  g_mat[step][k] <= (g_mat[step][k] > m_vec[step]) ? g_mat[step][k] : '0;
               step <= step + RB'(1);
            end
            WEI: if (w_acc) step <= step + RB'(1);
            OUT: if (o_acc) begin
               step <= step + RB'(1);
               if (step == R_LAST) begin
                  r_cnt <= '0;
                  c_cnt <= '0;
                  for (int i = 0; i < ROWS; i++) begin
                     s_vec[i] <= '0;
                     m_vec[i] <= '0;
                     for (int k = 0; k < ROWS; k++) g_mat[i][k] <= '0;
                     for (int c = 0; c < COLS; c++) a_mem[i][c] <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_lane
      dcsf_mac_lane #(
         .GW (GW),
         .WW (WW),
         .AW (AW),
         .OW (OW)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (lane_clr),
         .en  (w_acc),
         .w   (w_data),
         .t   (g_mat[i][step]),
         .y   (y_vec[i])
      );
   end

endmodule

// File: tb/tb_dcsf_gram_engine.sv
// Directed and randomized bench for dcsf_gram_engine with a plain-arithmetic model.
`timescale 1ns/1ps
module tb_dcsf_gram_engine;

   localparam int ROWS = 8;
   localparam int COLS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid, w_valid, o_ready;
   logic [7:0]  i_data, w_data;
   logic        i_ready, w_ready, o_valid, o_last;
   logic [31:0] o_data;
   logic        i_ready16, w_ready16, o_valid16, o_last16;
   logic [15:0] o_data16;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dcsf_gram_engine dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready)
   );

   dcsf_gram_engine #(.OW(16)) dut16 (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready16),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready16),
      .o_valid(o_valid16), .o_data(o_data16), .o_last(o_last16), .o_ready(o_ready)
   );

   logic [7:0] a_q [ROWS][COLS];
   logic [7:0] w_q [ROWS];
   longint     y_exp [ROWS];
   int         n_assert = 0;
   int         n_fail = 0;
   int         last_cyc = 0;
   string      cur = "reset";

   task automatic check(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0d expected %0d", cur, tag, obs, exp);
      end
   endtask

   function automatic longint fit32(input longint v);
      return v & 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic longint fit16(input longint v);
`ifdef DCSF_SAT_OUT_EN
      return (v > 65535) ? 64'd65535 : v;
`else
      return v & 64'hFFFF;
`endif
   endfunction

   // Gram matrix, row-mean threshold, matrix-vector product.
   task automatic run_model();
      longint g [ROWS][ROWS];
      longint s, m, t;
      for (int i = 0; i < ROWS; i++)
         for (int k = 0; k < ROWS; k++) begin
            g[i][k] = 0;
            for (int c = 0; c < COLS; c++)
               g[i][k] += longint'(a_q[i][c]) * longint'(a_q[k][c]);
         end
      for (int i = 0; i < ROWS; i++) begin
         s = 0;
         for (int k = 0; k < ROWS; k++) s += g[i][k];
         m = s / ROWS;
         y_exp[i] = 0;
         for (int k = 0; k < ROWS; k++) begin
            t = (g[i][k] > m) ? g[i][k] : 0;
            y_exp[i] += t * longint'(w_q[k]);
         end
      end
   endtask

   task automatic fill_ident(input logic [7:0] v);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) a_q[r][c] = (r == c) ? v : 8'd0;
   endtask

   task automatic send_matrix(input bit gaps, input int n_elem);
      int n, guard;
      n = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (n < n_elem) begin
               if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
               i_valid = 1'b1;
               i_data  = a_q[r][c];
               guard = 0;
               while (!i_ready && guard < 50) begin
                  @(negedge clk);
                  guard++;
               end
               if (guard >= 50) check("i_ready_timeout", 0, 1);
               last_cyc = cyc;
               @(negedge clk);
               i_valid = 1'b0;
               n++;
            end
   endtask

   task automatic wait_wready(input bit lat_chk, input bit junk);
      int guard;
      guard = 0;
      while (!w_ready && guard < 100) begin
         if (junk) begin
            i_valid = 1'b1; i_data = 8'($urandom);
            w_valid = 1'b1; w_data = 8'($urandom);
         end
         @(negedge clk);
         guard++;
      end
      i_valid = 1'b0;
      w_valid = 1'b0;
      check("w_ready_rise", w_ready, 1);
      if (lat_chk) check("w_ready_latency", cyc - last_cyc, 2 * ROWS + 2);
   endtask

   task automatic send_weights(input bit gaps);
      int guard;
      for (int j = 0; j < ROWS; j++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         w_valid = 1'b1;
         w_data  = w_q[j];
         guard = 0;
         while (!w_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) check("w_ready_timeout", 0, 1);
         @(negedge clk);
         w_valid = 1'b0;
      end
   endtask

   task automatic collect(input int stall_idx);
      int guard;
      check("o_valid_first", o_valid, 1);
      for (int i = 0; i < ROWS; i++) begin
         if (i == stall_idx) begin
            o_ready = 1'b0;
            repeat (3) begin
               check("stall_valid", o_valid, 1);
               check($sformatf("stall_y%0d", i), o_data, fit32(y_exp[i]));
               check("stall_last", o_last, 0);
               @(negedge clk);
            end
         end
         o_ready = 1'b1;
         guard = 0;
         while (!o_valid && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         check($sformatf("valid%0d", i), o_valid, 1);
         check($sformatf("y%0d", i), o_data, fit32(y_exp[i]));
         check($sformatf("y16_%0d", i), o_data16, fit16(y_exp[i]));
         check($sformatf("last%0d", i), o_last, (i == ROWS - 1) ? 1 : 0);
         @(negedge clk);
      end
      o_ready = 1'b0;
      check("o_valid_after", o_valid, 0);
      check("o_data_after", o_data, 0);
      check("i_ready_after", i_ready, 1);
      @(negedge clk);
      check("no_extra_word", o_valid, 0);
   endtask

   task automatic run_case(input string name, input bit gaps, input int stall, input bit lat);
      cur = name;
      run_model();
      send_matrix(gaps, ROWS * COLS);
      check("i_ready_busy", i_ready, 0);
      wait_wready(lat, gaps);
      send_weights(gaps);
      collect(stall);
   endtask

   initial begin
      i_valid = 1'b0; i_data = '0;
      w_valid = 1'b0; w_data = '0;
      o_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_i_ready", i_ready, 1);
      check("rst_w_ready", w_ready, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      check("rst_o_last", o_last, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) a_q[r][c] = 8'd1;
         w_q[r] = 8'd1;
      end
      run_case("all_ones", 0, -1, 0);

      fill_ident(8'd1);
      for (int j = 0; j < ROWS; j++) w_q[j] = 8'(j + 1);
      run_case("identity", 0, -1, 1);
      run_case("identity_gaps", 1, 2, 1);

      fill_ident(8'd255);
      for (int j = 0; j < ROWS; j++) w_q[j] = 8'd255;
      run_case("diag255", 0, -1, 0);

      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) a_q[r][c] = 8'($urandom);
         w_q[r] = 8'($urandom);
      end
      run_case("random", 1, int'($urandom_range(0, ROWS - 1)), 1);

      cur = "mid_reset";
      fill_ident(8'd1);
      for (int j = 0; j < ROWS; j++) w_q[j] = 8'(j + 1);
      send_matrix(0, 40);
      rst = 1'b1;
      #1;
      check("mr_i_ready", i_ready, 1);
      check("mr_w_ready", w_ready, 0);
      check("mr_o_valid", o_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_case("after_reset", 0, -1, 1);

      run_case("b2b_first", 0, -1, 1);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) a_q[r][c] = (r < 4) ? 8'd2 : 8'd1;
      for (int j = 0; j < ROWS; j++) w_q[j] = 8'($urandom_range(0, 255));
      run_case("b2b_second", 0, -1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
